// File: rtl/matmul_stream_engine.sv
// N x N matrix-multiply engine: loads A then B from a byte stream,
// computes C = A*B on one MAC and streams C out MSB byte first.
module matmul_stream_engine #(
    parameter int N      = 2,
    parameter int SIGNED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [1:0] state,
    output logic       done,
    output logic       drop
);

    localparam int ACC_W     = 16 + $clog2(N);
    localparam int OUT_BYTES = (ACC_W + 7) / 8;
    localparam int OW        = OUT_BYTES * 8;
    localparam int NN        = N * N;
    localparam int IW        = (NN > 1) ? $clog2(NN) : 1;
    localparam int KW        = (N > 1) ? $clog2(N) : 1;
    localparam int BW        = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(OUT_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        SEND    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } phase_t;

    state_t state_q, state_d;
    phase_t phase_q;

    logic [7:0]       a_mem [NN];
    logic [7:0]       b_mem [NN];
    logic [ACC_W-1:0] c_mem [NN];

    logic [IW-1:0]    idx, e;
    logic [KW-1:0]    i, j, k;
    logic [BW-1:0]    b;
    logic [ACC_W-1:0] acc;

    logic             load, last_load, k_last, mac_last;
    logic             byte_done, elem_last;
    logic [IW-1:0]    a_idx, b_idx, c_idx;
    logic [ACC_W-1:0] a_ext, b_ext, prod, sum;
    logic [OW-1:0]    c_ext;
    logic [7:0]       tx_byte;

    assign state = state_q;

    // The cycle carrying done already reads LOAD_A, but must not load.
    always_comb begin
        load      = rx_valid && !done &&
                    (state_q == LOAD_A || state_q == LOAD_B);
        last_load = load && (idx == IDX_LAST);
        k_last    = (k == K_LAST);
        mac_last  = k_last && (j == K_LAST) && (i == K_LAST);
        byte_done = (state_q == SEND) && (phase_q == WAIT_LO) && !tx_busy;
        elem_last = (b == B_LAST) && (e == IDX_LAST);
        a_idx     = IW'(i * N + k);
        b_idx     = IW'(k * N + j);
        c_idx     = IW'(i * N + j);
        a_ext     = (SIGNED != 0) ? ACC_W'($signed(a_mem[a_idx]))
                                  : ACC_W'(a_mem[a_idx]);
        b_ext     = (SIGNED != 0) ? ACC_W'($signed(b_mem[b_idx]))
                                  : ACC_W'(b_mem[b_idx]);
        prod      = a_ext * b_ext;
        sum       = (k == '0) ? prod : acc + prod;
        c_ext     = (SIGNED != 0) ? OW'($signed(c_mem[e]))
                                  : OW'(c_mem[e]);
        tx_byte   = c_ext[(OUT_BYTES - 1 - int'(b)) * 8 +: 8];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A:  if (last_load) state_d = LOAD_B;
            LOAD_B:  if (last_load) state_d = COMPUTE;
            COMPUTE: if (mac_last) state_d = SEND;
            SEND:    if (byte_done && elem_last) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD_A;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (load && state_q == LOAD_A) a_mem[idx] <= rx_data;
        if (load && state_q == LOAD_B) b_mem[idx] <= rx_data;
        if (state_q == COMPUTE && k_last) c_mem[c_idx] <= sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= ISSUE;
            idx      <= '0;
            e        <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            b        <= '0;
            acc      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (rx_valid && !load) drop <= 1'b1;
            if (load) idx <= last_load ? '0 : idx + 1'b1;
            if (last_load && state_q == LOAD_B) begin
                i <= '0;
                j <= '0;
                k <= '0;
            end
            if (state_q == COMPUTE) begin
                acc <= sum;
                k   <= k_last ? '0 : k + 1'b1;
                if (k_last) begin
                    j <= (j == K_LAST) ? '0 : j + 1'b1;
                    if (j == K_LAST) i <= (i == K_LAST) ? '0 : i + 1'b1;
                end
                if (mac_last) begin
                    e       <= '0;
                    b       <= '0;
                    phase_q <= ISSUE;
                end
            end
            // One byte in flight: issue, see busy rise, see busy fall.
            if (state_q == SEND) begin
                unique case (phase_q)
                    ISSUE: if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= tx_byte;
                        phase_q  <= WAIT_HI;
                    end
                    WAIT_HI: if (tx_busy) phase_q <= WAIT_LO;
                    WAIT_LO: if (!tx_busy) begin
                        phase_q <= ISSUE;
                        b       <= (b == B_LAST) ? '0 : b + 1'b1;
                        if (b == B_LAST) e <= (e == IDX_LAST) ? '0 : e + 1'b1;
                        if (elem_last) begin
                            done <= 1'b1;
                            idx  <= '0;
                        end
                    end
                    default: phase_q <= ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Scoreboard bench: four engines (N=2 unsigned, N=2 signed, N=3, N=1)
// share one expected-byte queue; a monitor pops it on every tx_start.
module tb_matmul_stream_engine;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst  [4];
    logic [7:0] rxd  [4];
    logic       rxv  [4];
    logic       busy [4];
    logic [7:0] td   [4];
    logic       ts   [4];
    logic [1:0] st   [4];
    logic       dn   [4];
    logic       dr   [4];

    int         cnt [4];
    int         stretch_at [4];
    int         pulses [4];
    int         comp_cyc [4];
    bit         outst [4];
    bit         hi [4];
    logic [7:0] hold [4];

    exp_t       exp_q [$];
    logic [7:0] stim [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        matmul_stream_engine #(
            .N      (g == 2 ? 3 : (g == 3 ? 1 : 2)),
            .SIGNED (g == 1 ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .rx_data  (rxd[g]),
            .rx_valid (rxv[g]),
            .tx_busy  (busy[g]),
            .tx_data  (td[g]),
            .tx_start (ts[g]),
            .state    (st[g]),
            .done     (dn[g]),
            .drop     (dr[g])
        );
        assign busy[g] = (cnt[g] != 0);
    end

    // Transmitter model: 20 busy cycles per byte, one chosen byte 200.
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (cnt[g] != 0) cnt[g] <= cnt[g] - 1;
            else if (ts[g]) cnt[g] <= (pulses[g] == stretch_at[g]) ? 200 : 20;
        end
    end

    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (rst[g]) begin
                    outst[g] = 0;
                end else begin
                    if (st[g] == 2'd2) comp_cyc[g]++;
                    if (ts[g]) begin
                        pulses[g]++;
                        checks++;
                        if (busy[g] || outst[g]) begin
                            errors++;
                            $display("FAIL handshake inst %0d: busy=%0b outstanding=%0b, required 0/0",
                                     g, busy[g], outst[g]);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_tx inst %0d: got %02h, required no byte", g, td[g]);
                        end else begin
                            ex = exp_q.pop_front();
                            if (ex.g != 2'(g) || ex.d != td[g]) begin
                                errors++;
                                $display("FAIL tx_byte: got inst %0d %02h, required inst %0d %02h",
                                         g, td[g], ex.g, ex.d);
                            end
                        end
                        outst[g] = 1;
                        hi[g]    = 0;
                        hold[g]  = td[g];
                    end else if (outst[g]) begin
                        checks++;
                        if (td[g] != hold[g]) begin
                            errors++;
                            $display("FAIL tx_data_stable inst %0d: got %02h, required %02h",
                                     g, td[g], hold[g]);
                        end
                        if (busy[g]) hi[g] = 1;
                        else if (hi[g]) outst[g] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    task automatic push_byte(input int g, input logic [7:0] d);
        exp_q.push_back({2'(g), d});
    endtask

    task automatic push_val(input int g, input logic [23:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) push_byte(g, v[i*8 +: 8]);
    endtask

    task automatic send_all(input int g);
        foreach (stim[i]) begin
            @(negedge clk);
            rxd[g] = stim[i];
            rxv[g] = 1'b1;
            @(negedge clk);
            rxv[g] = 1'b0;
        end
        stim.delete();
    endtask

    task automatic load_basic(input int g);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_all(g);
    endtask

    task automatic exp_basic(input int g);
        push_val(g, 24'h000013, 3);
        push_val(g, 24'h000016, 3);
        push_val(g, 24'h00002B, 3);
        push_val(g, 24'h000032, 3);
    endtask

    task automatic wait_done(input int g, input int p0, input int c0,
                             input int np, input int nc, input int drp);
        int n = 0;
        while (!dn[g] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(dn[g]), 1);
        chk("state_at_done", int'(st[g]), 0);
        chk("drop_at_done", int'(dr[g]), drp);
        chk("tx_count", pulses[g] - p0, np);
        chk("compute_cycles", comp_cyc[g] - c0, nc);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int p0, c0, n;
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b1;
            rxv[g] = 1'b0;
            rxd[g] = '0;
            stretch_at[g] = -1;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("reset_state", int'(st[g]), 0);
            chk("reset_tx_start", int'(ts[g]), 0);
            chk("reset_tx_data", int'(td[g]), 0);
            chk("reset_done", int'(dn[g]), 0);
            chk("reset_drop", int'(dr[g]), 0);
            rst[g] = 1'b0;
        end

        // Basic unsigned N=2
        p0 = pulses[0]; c0 = comp_cyc[0];
        exp_basic(0);
        load_basic(0);
        wait_done(0, p0, c0, 12, 8, 0);

        // Unsigned maximum with one stretched byte
        p0 = pulses[0]; c0 = comp_cyc[0];
        stretch_at[0] = p0 + 4;
        for (int i = 0; i < 4; i++) push_val(0, 24'h01FC02, 3);
        for (int i = 0; i < 8; i++) stim.push_back(8'hFF);
        send_all(0);
        wait_done(0, p0, c0, 12, 8, 0);
        stretch_at[0] = -1;

        // Byte injected two cycles into COMPUTE
        p0 = pulses[0]; c0 = comp_cyc[0];
        exp_basic(0);
        load_basic(0);
        @(negedge clk);
        rxd[0] = 8'hAA;
        rxv[0] = 1'b1;
        @(negedge clk);
        rxv[0] = 1'b0;
        @(negedge clk);
        chk("drop_rise", int'(dr[0]), 1);
        chk("state_compute", int'(st[0]), 2);
        wait_done(0, p0, c0, 12, 8, 1);

        // Reset after five bytes of SEND
        p0 = pulses[0];
        push_val(0, 24'h000013, 3);
        push_byte(0, 8'h00);
        push_byte(0, 8'h00);
        load_basic(0);
        n = 0;
        while (pulses[0] - p0 < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bytes_before_rst", pulses[0] - p0, 5);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", int'(st[0]), 0);
        chk("rst_mid_tx_start", int'(ts[0]), 0);
        chk("rst_mid_tx_data", int'(td[0]), 0);
        chk("rst_mid_done", int'(dn[0]), 0);
        chk("rst_mid_drop", int'(dr[0]), 0);
        rst[0] = 1'b0;
        repeat (300) @(negedge clk);
        chk("no_tx_after_rst", pulses[0] - p0, 5);
        chk("queue_empty_rst", exp_q.size(), 0);
        p0 = pulses[0]; c0 = comp_cyc[0];
        exp_basic(0);
        load_basic(0);
        wait_done(0, p0, c0, 12, 8, 0);

        // Signed N=2: A = -I
        p0 = pulses[1]; c0 = comp_cyc[1];
        push_val(1, 24'hFFFFFE, 3);
        push_val(1, 24'hFFFFFD, 3);
        push_val(1, 24'hFFFFFC, 3);
        push_val(1, 24'hFFFFFB, 3);
        stim = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h02, 8'h03, 8'h04, 8'h05};
        send_all(1);
        wait_done(1, p0, c0, 12, 8, 0);

        // N=3: A = 1..9, B = diag(1,2,3)
        p0 = pulses[2]; c0 = comp_cyc[2];
        push_val(2, 24'd1, 3);  push_val(2, 24'd4, 3);  push_val(2, 24'd9, 3);
        push_val(2, 24'd4, 3);  push_val(2, 24'd10, 3); push_val(2, 24'd18, 3);
        push_val(2, 24'd7, 3);  push_val(2, 24'd16, 3); push_val(2, 24'd27, 3);
        for (int i = 1; i <= 9; i++) stim.push_back(8'(i));
        stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'h00);
        stim.push_back(8'h00); stim.push_back(8'h02); stim.push_back(8'h00);
        stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h03);
        send_all(2);
        wait_done(2, p0, c0, 27, 27, 0);

        // N=1: FF*FF = FE01 in two bytes
        p0 = pulses[3]; c0 = comp_cyc[3];
        push_val(3, 24'h00FE01, 2);
        stim = '{8'hFF, 8'hFF};
        send_all(3);
        wait_done(3, p0, c0, 2, 1, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
